// File: rtl/wbs_bram_responder.sv
// Pipelined Wishbone slave in front of a single-port word memory.
// Writes commit at the accepting edge; reads sample the memory at the accepting
// edge. Every accepted request then travels down a LATENCY-stage pipeline and
// produces a one-cycle wbs_ack. An outstanding counter throttles acceptance
// through wbs_stall. Dropping wbs_cycle aborts every request still in flight.
module wbs_bram_responder #(
    parameter int AW              = 8,
    parameter int DW              = 16,
    parameter int LATENCY         = 3,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   wbs_address,
    input  logic [DW-1:0] wbs_writedata,
    output logic [DW-1:0] wbs_readdata,
    input  logic          wbs_strobe,
    input  logic          wbs_cycle,
    input  logic          wbs_write,
    output logic          wbs_ack,
    output logic          wbs_stall,
    input  logic          stall_inject
);

    localparam int            CW      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);
    localparam int            DEPTH   = 1 << AW;

    // Word storage.
    logic [DW-1:0] mem [DEPTH];

    // Upper address bits are dropped, so addresses alias modulo DEPTH.
    logic [AW-1:0] word_addr;
    logic          accept;
    logic          launch;
    logic [CW-1:0] outstanding;

    // Read and write requests travel in separate valid pipelines. Their OR is
    // the ack, and the read pipeline alone decides when wbs_readdata reloads.
    logic [LATENCY-1:0] rd_q;
    logic [LATENCY-1:0] wr_q;
    logic [LATENCY-1:0] rd_in;
    logic [LATENCY-1:0] wr_in;

    // The last data stage is wbs_readdata itself. It reloads only when a read
    // enters that stage, so it holds across write acks and idle cycles.
    logic [DW-1:0] data_q  [LATENCY];
    logic [DW-1:0] data_in [LATENCY];

    assign word_addr    = wbs_address[AW-1:0];
    assign wbs_stall    = stall_inject | (outstanding == CNT_MAX);
    assign accept       = wbs_cycle & wbs_strobe & ~wbs_stall;
    assign wbs_ack      = rd_q[LATENCY-1] | wr_q[LATENCY-1];
    assign wbs_readdata = data_q[LATENCY-1];

    // A request leaves the counted window at the edge where it enters the
    // ack stage. With MAX_OUTSTANDING == LATENCY that frees a slot at the same
    // edge as the next accept, which sustains one request per cycle.
    assign launch = rd_in[LATENCY-1] | wr_in[LATENCY-1];

    // Next-state values for each stage: stage 0 is fed by the accepted
    // request, and every later stage is fed by the stage before it.
    always_comb begin
        // NOTE: every always_comb output gets a value on every pass; a missing default infers a latch.
        rd_in      = '0;
        wr_in      = '0;
        rd_in[0]   = accept & ~wbs_write;
        wr_in[0]   = accept & wbs_write;
        data_in[0] = mem[word_addr];
        for (int i = 1; i < LATENCY; i++) begin
            rd_in[i]   = rd_q[i-1];
            wr_in[i]   = wr_q[i-1];
            data_in[i] = data_q[i-1];
        end
    end

    // Memory write port. A write commits at its accepting edge, so a read
    // accepted on the next edge already sees the new word.
    // NOTE: the memory array has no reset, which lets it map onto block RAM; contents start undefined.
    always_ff @(posedge clk) begin
        if (accept && wbs_write) begin
            mem[word_addr] <= wbs_writedata;
        end
    end

    // Shift the request pipeline and track outstanding requests. An abort
    // clears both; a reset also clears the data stages and wbs_readdata.
    // NOTE: sequential state uses non-blocking assignments only, so every stage samples the pre-edge value of its neighbour.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q        <= '0;
            wr_q        <= '0;
            outstanding <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else if (!wbs_cycle) begin
            rd_q        <= '0;
            wr_q        <= '0;
            outstanding <= '0;
        end else begin
            rd_q <= rd_in;
            wr_q <= wr_in;
            for (int i = 0; i < LATENCY; i++) begin
                if (i < LATENCY - 1 || rd_in[LATENCY-1]) begin
                    data_q[i] <= data_in[i];
                end
            end
            if (accept && !launch) begin
                outstanding <= outstanding + CW'(1);
            end else if (!accept && launch) begin
                outstanding <= outstanding - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_wbs_bram_responder.sv
// Testbench for wbs_bram_responder.
// Instance u0 uses LATENCY=3, MAX_OUTSTANDING=3 and is checked by a
// scoreboard: the driver queues an expected ack for each accepted request,
// and a monitor on the falling edge compares each ack against that queue.
// Instance u1 uses LATENCY=3, MAX_OUTSTANDING=2 and covers abort and throttling.
module tb_wbs_bram_responder;

    localparam int LAT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [31:0] adr0;
    logic [15:0] wdat0, rdat0;
    logic        stb0, cyc0, we0, ack0, stall0, inj0;

    logic [31:0] adr1;
    logic [15:0] wdat1, rdat1;
    logic        stb1, cyc1, we1, ack1, stall1, inj1;

    wbs_bram_responder #(.AW(8), .DW(16), .LATENCY(LAT), .MAX_OUTSTANDING(3)) u0 (
        .clk(clk), .reset(rst_n),
        .wbs_address(adr0), .wbs_writedata(wdat0), .wbs_readdata(rdat0),
        .wbs_strobe(stb0), .wbs_cycle(cyc0), .wbs_write(we0),
        .wbs_ack(ack0), .wbs_stall(stall0), .stall_inject(inj0)
    );

    wbs_bram_responder #(.AW(8), .DW(16), .LATENCY(LAT), .MAX_OUTSTANDING(2)) u1 (
        .clk(clk), .reset(rst_n),
        .wbs_address(adr1), .wbs_writedata(wdat1), .wbs_readdata(rdat1),
        .wbs_strobe(stb1), .wbs_cycle(cyc1), .wbs_write(we1),
        .wbs_ack(ack1), .wbs_stall(stall1), .stall_inject(inj1)
    );

    typedef struct packed {
        logic        rd;
        logic [15:0] data;
        logic [31:0] due;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] model [256];
    logic [15:0] last_rd;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          ack_cnt0 = 0;
    int          acc_cnt0 = 0;
    int          ack_cnt1 = 0;
    logic [31:0] cyc_n    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Scoreboard monitor for u0: every ack must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_rd = '0;
            exp_q.delete();
        end else if (ack0) begin
            ack_cnt0++;
            check("ack_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("ack_cycle", cyc_n, e.due);
                if (e.rd) begin
                    check("read_data", 32'(rdat0), 32'(e.data));
                    last_rd = e.data;
                end else begin
                    check("write_ack_hold", 32'(rdat0), 32'(last_rd));
                end
            end
        end
    end

    always @(negedge clk) if (rst_n && ack1) ack_cnt1++;

    // Present one request to u0 and hold it until accepted; queue its expected ack.
    task automatic issue(input logic wr, input logic [31:0] a, input logic [15:0] d,
                         input bit rand_inj, output int waits);
        bit done;
        done  = 0;
        waits = 0;
        cyc0  = 1'b1;
        stb0  = 1'b1;
        we0   = wr;
        adr0  = a;
        wdat0 = d;
        while (!done) begin
            if (rand_inj) inj0 = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            if (!stall0) begin
                done = 1;
                @(posedge clk); #1;
                acc_cnt0++;
                exp_q.push_back('{rd: !wr, data: (wr ? 16'h0 : model[a[7:0]]), due: cyc_n + LAT - 1});
                if (wr) model[a[7:0]] = d;
            end else begin
                waits++;
                @(posedge clk); #1;
                if (waits > 40) begin
                    check("issue_timeout", 32'(waits), 32'd0);
                    done = 1;
                end
            end
        end
        stb0 = 1'b0;
        inj0 = 1'b0;
    endtask

    task automatic idle(input int n);
        stb0 = 1'b0;
        stb1 = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, wsum, a_snap, acc_snap, acc1, out1;
        logic [7:0] ra;
        rst_n = 1'b0;
        {stb0, cyc0, we0, inj0} = '0;
        {stb1, cyc1, we1, inj1} = '0;
        adr0 = '0; wdat0 = '0; adr1 = '0; wdat1 = '0;

        // Reset state: outputs forced low, stall follows stall_inject.
        inj0 = 1'b1;
        #3;
        check("rst_ack", 32'(ack0), 32'd0);
        check("rst_readdata", 32'(rdat0), 32'd0);
        check("rst_stall_inject", 32'(stall0), 32'd1);
        inj0 = 1'b0;
        #1;
        check("rst_stall_clear", 32'(stall0), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Write then read address 0x01; the write is accepted on the first edge after reset.
        issue(1'b1, 32'h01, 16'h0101, 0, w);
        check("first_edge_accept", 32'(w), 32'd0);
        issue(1'b0, 32'h01, 16'h0, 0, w);
        idle(5);

        // Stream 256 writes then 256 reads back to back with no stall.
        a_snap = ack_cnt0;
        wsum   = 0;
        for (int i = 0; i < 256; i++) begin
            issue(1'b1, 32'(i), {8'(i), 8'(i)}, 0, w);
            wsum += w;
        end
        idle(5);
        check("write_pass_acks", 32'(ack_cnt0 - a_snap), 32'd256);
        a_snap = ack_cnt0;
        for (int i = 0; i < 256; i++) begin
            issue(1'b0, 32'(i), 16'h0, 0, w);
            wsum += w;
        end
        idle(5);
        check("read_pass_acks", 32'(ack_cnt0 - a_snap), 32'd256);
        check("stream_no_stall", 32'(wsum), 32'd0);

        // Upper address bits alias: 0x17A reads word 0x7A, 0x105 writes word 0x05.
        issue(1'b0, 32'h17A, 16'h0, 0, w);
        issue(1'b1, 32'h105, 16'h1234, 0, w);
        issue(1'b0, 32'h005, 16'h0, 0, w);
        idle(5);

        // u1: two reads accepted, cycle dropped next cycle -> no acks, counter cleared.
        cyc1 = 1'b1; stb1 = 1'b1; we1 = 1'b0; adr1 = 32'h3;
        @(negedge clk); check("abort_stall_e0", 32'(stall1), 32'd0);
        @(posedge clk); #1;
        @(negedge clk); check("abort_stall_e1", 32'(stall1), 32'd0);
        @(posedge clk); #1;
        a_snap = ack_cnt1;
        cyc1 = 1'b0; stb1 = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); check("abort_stall_after", 32'(stall1), 32'd0);
        cyc1 = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_acks", 32'(ack_cnt1 - a_snap), 32'd0);

        // u1: strobe held high -> stall every third cycle, at most 2 outstanding.
        stb1 = 1'b1; we1 = 1'b1; wdat1 = 16'h5555; acc1 = 0;
        a_snap = ack_cnt1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("throttle_stall", 32'(stall1), 32'((i % 3) == 2));
            if (!stall1) acc1++;
            @(posedge clk); #1;
            out1 = acc1 - (ack_cnt1 - a_snap);
            check("throttle_outstanding", 32'(out1 <= 2), 32'd1);
        end
        idle(5);
        check("throttle_accepts", 32'(acc1), 32'd8);
        check("throttle_acks", 32'(ack_cnt1 - a_snap), 32'd8);

        // 1000 random requests with random stall injection.
        a_snap   = ack_cnt0;
        acc_snap = acc_cnt0;
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            issue(1'($urandom_range(0, 1)), 32'(ra),
                  ($urandom_range(0, 1) != 0) ? 16'hDEAD : 16'hBEEF, 1, w);
        end
        idle(6);
        check("random_acks_eq_accepts", 32'(ack_cnt0 - a_snap), 32'(acc_cnt0 - acc_snap));
        check("random_accepts", 32'(acc_cnt0 - acc_snap), 32'd1000);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        // Reset with two requests in flight: ack pulled low at once, nothing after release.
        issue(1'b0, 32'h7A, 16'h0, 0, w);
        issue(1'b1, 32'h10, 16'h5A5A, 0, w);
        issue(1'b0, 32'h20, 16'h0, 0, w);
        @(posedge clk); #2;
        check("ack_before_reset", 32'(ack0), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ack", 32'(ack0), 32'd0);
        check("mid_rst_readdata", 32'(rdat0), 32'd0);
        inj0 = 1'b1;
        #1;
        check("mid_rst_stall_inject", 32'(stall0), 32'd1);
        inj0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        a_snap = ack_cnt0;
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_no_acks", 32'(ack_cnt0 - a_snap), 32'd0);
        issue(1'b0, 32'h10, 16'h0, 0, w);
        check("post_rst_accept", 32'(w), 32'd0);
        idle(5);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
